// File: rtl/gstmcu_pkg.sv
// Shared definitions for the GSTMCU sound DMA block: register indices and FSM states.
package gstmcu_pkg;

  localparam logic [5:0] RegCtrl     = 6'h00;
  localparam logic [5:0] RegStartHi  = 6'h01;
  localparam logic [5:0] RegStartMid = 6'h02;
  localparam logic [5:0] RegStartLo  = 6'h03;
  localparam logic [5:0] RegCurHi    = 6'h04;
  localparam logic [5:0] RegCurMid   = 6'h05;
  localparam logic [5:0] RegCurLo    = 6'h06;
  localparam logic [5:0] RegEndHi    = 6'h07;
  localparam logic [5:0] RegEndMid   = 6'h08;
  localparam logic [5:0] RegEndLo    = 6'h09;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLd1,
    StLd2,
    StAdv
  } snd_state_e;

endpackage

// File: rtl/ste_snd_dma_ctrl.sv
// STE sound DMA controller: CPU register window, frame address sequencing and the
// request / load-strobe / advance fetch cycle towards the MCU arbiter and shifter.
module ste_snd_dma_ctrl
  import gstmcu_pkg::*;
(
  input  logic        clk32,
  input  logic        reset,
  input  logic        CS,
  input  logic        RW,
  input  logic [6:1]  A,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        sreq,
  input  logic        dma_ack,
  output logic        dma_req,
  output logic [23:1] addr,
  output logic        SLOAD_N,
  output logic        sint
);

  snd_state_e  state_q, state_d;
  logic        en_q, en_d;
  logic        loop_q, loop_d;
  logic        empty_q, empty_d;
  logic [22:0] start_q, start_d;
  logic [22:0] end_q, end_d;
  logic [22:0] act_end_q, act_end_d;
  logic [22:0] addr_q, addr_d;

  logic        wr, ctrl_wr, en_rise, frame_end;
  logic [22:0] addr_inc;
  logic [7:0]  rd_byte;
  logic        unused_din;

  assign unused_din = ^DIN[15:8];

  assign wr       = CS && !RW;
  assign ctrl_wr  = wr && (A == RegCtrl);
  assign en_rise  = ctrl_wr && DIN[0] && !en_q;
  assign addr_inc = addr_q + 23'd1;
  // A frame end only counts while enabled; a CPU clear landing in ADV also suppresses it.
  assign frame_end = (state_q == StAdv) && (addr_inc == act_end_q) && en_q &&
                     !(ctrl_wr && !DIN[0]);

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    loop_d    = loop_q;
    empty_d   = 1'b0;
    start_d   = start_q;
    end_d     = end_q;
    act_end_d = act_end_q;
    addr_d    = addr_q;

    case (state_q)
      StIdle: if (en_q && sreq) state_d = StReq;
      StReq:  if (dma_ack) state_d = StLd1;
      StLd1:  state_d = StLd2;
      StLd2:  state_d = StAdv;
      StAdv: begin
        state_d = StIdle;
        addr_d  = addr_inc;
        if (frame_end) begin
          if (loop_q) begin
            addr_d    = start_q;
            act_end_d = end_q;
          end else begin
            en_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // CPU writes are applied last so they take priority over the FSM's en clear.
    if (wr) begin
      case (A)
        RegCtrl: begin
          en_d   = DIN[0];
          loop_d = DIN[1];
          if (en_rise) begin
            addr_d    = start_q;
            act_end_d = end_q;
            if (start_q >= end_q) begin
              en_d    = 1'b0;
              empty_d = 1'b1;
            end
          end
        end
        RegStartHi:  start_d[22:15] = DIN[7:0];
        RegStartMid: start_d[14:7]  = DIN[7:0];
        RegStartLo:  start_d[6:0]   = DIN[7:1];
        RegEndHi:    end_d[22:15]   = DIN[7:0];
        RegEndMid:   end_d[14:7]    = DIN[7:0];
        RegEndLo:    end_d[6:0]     = DIN[7:1];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      loop_q    <= 1'b0;
      empty_q   <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      act_end_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      loop_q    <= loop_d;
      empty_q   <= empty_d;
      start_q   <= start_d;
      end_q     <= end_d;
      act_end_q <= act_end_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (A)
      RegCtrl:     rd_byte = {6'b0, loop_q, en_q};
      RegStartHi:  rd_byte = start_q[22:15];
      RegStartMid: rd_byte = start_q[14:7];
      RegStartLo:  rd_byte = {start_q[6:0], 1'b0};
      RegCurHi:    rd_byte = addr_q[22:15];
      RegCurMid:   rd_byte = addr_q[14:7];
      RegCurLo:    rd_byte = {addr_q[6:0], 1'b0};
      RegEndHi:    rd_byte = end_q[22:15];
      RegEndMid:   rd_byte = end_q[14:7];
      RegEndLo:    rd_byte = {end_q[6:0], 1'b0};
      default:     rd_byte = 8'h00;
    endcase
  end

  assign DOUT    = (CS && RW) ? {8'h00, rd_byte} : 16'h0000;
  assign addr    = addr_q;
  // Outputs are forced inactive during reset so they are clean before the first edge.
  assign dma_req = !reset && (state_q == StReq);
  assign SLOAD_N = reset || !((state_q == StLd1) || (state_q == StLd2));
  assign sint    = !reset && (frame_end || empty_q);

endmodule

// File: tb/tb_ste_snd_dma_ctrl.sv
// Bench for ste_snd_dma_ctrl: directed scenarios plus random single frames checked
// against a frame-level model of the expected fetch address sequence.
module tb_ste_snd_dma_ctrl;
  import gstmcu_pkg::*;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        CS = 1'b0;
  logic        RW = 1'b1;
  logic [5:0]  A = '0;
  logic [15:0] DIN = '0;
  logic [15:0] DOUT;
  logic        sreq = 1'b1;
  logic        dma_ack;
  logic        dma_req;
  logic [22:0] addr;
  logic        SLOAD_N;
  logic        sint;

  int checks = 0;
  int errors = 0;
  int ack_lat = 2;
  bit auto_ack = 1'b1;

  logic [22:0] fetch_q[$];
  logic [22:0] exp_q[$];
  int sload_cnt = 0;
  int sint_cnt = 0;
  int req_cnt = 0;

  ste_snd_dma_ctrl dut (
    .clk32   (clk32),
    .reset   (reset),
    .CS      (CS),
    .RW      (RW),
    .A       (A),
    .DIN     (DIN),
    .DOUT    (DOUT),
    .sreq    (sreq),
    .dma_ack (dma_ack),
    .dma_req (dma_req),
    .addr    (addr),
    .SLOAD_N (SLOAD_N),
    .sint    (sint)
  );

  initial forever #5 clk32 = ~clk32;

  // Arbiter model: grant ack_lat cycles after a request is seen, for one cycle.
  initial begin
    int req_age;
    req_age = 0;
    dma_ack = 1'b0;
    forever begin
      @(posedge clk32);
      #1;
      if (dma_ack) dma_ack = 1'b0;
      else if (dma_req && auto_ack) begin
        if (req_age + 1 >= ack_lat) begin
          dma_ack = 1'b1;
          req_age = 0;
        end else req_age++;
      end else req_age = 0;
    end
  end

  always @(negedge clk32) begin
    if (!reset) begin
      if (dma_req && dma_ack) fetch_q.push_back(addr);
      if (!SLOAD_N) sload_cnt <= sload_cnt + 1;
      if (sint) sint_cnt <= sint_cnt + 1;
      if (dma_req) req_cnt <= req_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [5:0] a, input logic [7:0] d);
    CS = 1'b1; RW = 1'b0; A = a; DIN = {8'($urandom), d};
    step(1);
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic reg_rd(input logic [5:0] a, output logic [15:0] v);
    CS = 1'b1; RW = 1'b1; A = a;
    #1;
    v = DOUT;
    CS = 1'b0;
  endtask

  task automatic rd_addr3(input logic [5:0] base, output logic [23:0] v);
    logic [15:0] b0, b1, b2;
    reg_rd(base, b0);
    reg_rd(base + 6'd1, b1);
    reg_rd(base + 6'd2, b2);
    v = {b0[7:0], b1[7:0], b2[7:0]};
  endtask

  task automatic set_frame(input logic [22:0] s, input logic [22:0] e);
    logic [23:0] sb, eb;
    sb = {s, 1'b0};
    eb = {e, 1'b0};
    reg_wr(RegStartHi, sb[23:16]); reg_wr(RegStartMid, sb[15:8]); reg_wr(RegStartLo, sb[7:0]);
    reg_wr(RegEndHi, eb[23:16]);   reg_wr(RegEndMid, eb[15:8]);   reg_wr(RegEndLo, eb[7:0]);
  endtask

  // Frame model: words start..end-1 in order, repeated per wrap; nothing if start >= end.
  task automatic model_frame(input logic [22:0] s, input logic [22:0] e, input int reps);
    logic [22:0] w;
    exp_q.delete();
    if (s < e) begin
      repeat (reps) begin
        w = s;
        while (w != e) begin
          exp_q.push_back(w);
          w = w + 23'd1;
        end
      end
    end
  endtask

  task automatic cmp_fetches(input string tag, input int base, input bit exact);
    if (exact) chk({tag, "_count"}, 32'(fetch_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < fetch_q.size()) chk({tag, "_addr"}, 32'(fetch_q[base + i]), 32'(exp_q[i]));
      else chk({tag, "_missing"}, 32'(fetch_q.size()), 32'(base + i + 1));
    end
  endtask

  task automatic wait_sints(input int k, input string tag);
    int n = 0;
    while (sint_cnt < k && n < 400) begin step(); n++; end
    chk({tag, "_sint_wait"}, 32'(sint_cnt >= k), 32'd1);
  endtask

  task automatic wait_fetches(input int k, input string tag);
    int n = 0;
    while (fetch_q.size() < k && n < 400) begin step(); n++; end
    chk({tag, "_fetch_wait"}, 32'(fetch_q.size() >= k), 32'd1);
  endtask

  task automatic wait_sload(input string tag);
    int n = 0;
    while (SLOAD_N !== 1'b0 && n < 100) begin step(); n++; end
    chk({tag, "_sload_wait"}, 32'(SLOAD_N), 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (dma_req !== 1'b1 && n < 100) begin step(); n++; end
    chk({tag, "_req_wait"}, 32'(dma_req), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    logic [15:0] v;
    for (int i = 0; i < 10; i++) begin
      reg_rd(6'(i), v);
      chk(tag, 32'(v), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [23:0] a24;
    logic [22:0] f, w, s, e;
    int fb, sb, lb, rb;

    // Reset state
    step(3);
    chk("rst_dma_req", 32'(dma_req), 32'd0);
    chk("rst_sload_n", 32'(SLOAD_N), 32'd1);
    chk("rst_sint", 32'(sint), 32'd0);
    chk_all_zero("rst_regs");
    reset = 1'b0;
    step(2);

    // Register map: read-only current addr, unmapped index, start bit0
    reg_wr(RegCurHi, 8'hFF);
    reg_rd(RegCurHi, v);        chk("cur_ro", 32'(v), 32'd0);
    reg_wr(6'h0A, 8'hFF);
    reg_rd(6'h0A, v);           chk("unmapped_0a", 32'(v), 32'd0);
    reg_rd(6'h3F, v);           chk("unmapped_3f", 32'(v), 32'd0);
    reg_wr(RegStartLo, 8'h01);
    reg_rd(RegStartLo, v);      chk("start_bit0", 32'(v), 32'd0);
    chk("dout_idle", 32'(DOUT), 32'd0);

    // Basic fetch
    set_frame(23'h80, 23'h82);
    rd_addr3(RegStartHi, a24);  chk("start_rb", 32'(a24), 32'h000100);
    rd_addr3(RegEndHi, a24);    chk("end_rb", 32'(a24), 32'h000104);
    fb = fetch_q.size(); sb = sint_cnt; lb = sload_cnt;
    reg_wr(RegCtrl, 8'h01);
    chk("rise_addr", 32'(addr), 32'h80);
    chk("rise_no_req", 32'(dma_req), 32'd0);
    wait_sints(sb + 1, "basic");
    step(10);
    model_frame(23'h80, 23'h82, 1);
    cmp_fetches("basic", fb, 1'b1);
    chk("basic_sload", 32'(sload_cnt - lb), 32'd4);
    chk("basic_sint", 32'(sint_cnt - sb), 32'd1);
    reg_rd(RegCtrl, v);         chk("basic_en", 32'(v), 32'd0);
    rd_addr3(RegCurHi, a24);    chk("basic_cur", 32'(a24), 32'h000104);

    // Loop
    fb = fetch_q.size(); sb = sint_cnt;
    reg_wr(RegCtrl, 8'h03);
    wait_sints(sb + 3, "loop");
    model_frame(23'h80, 23'h82, 3);
    cmp_fetches("loop", fb, 1'b1);
    reg_rd(RegCtrl, v);         chk("loop_en", 32'(v), 32'd3);

    // Mid-frame reprogram of start
    fb = fetch_q.size();
    wait_fetches(fb + 1, "reprog");
    f = fetch_q[fb];
    reg_wr(RegStartMid, 8'h02);
    exp_q.delete();
    w = f;
    while (w != 23'h82) begin exp_q.push_back(w); w = w + 23'd1; end
    exp_q.push_back(23'h100);
    wait_fetches(fb + exp_q.size(), "reprog");
    cmp_fetches("reprog", fb, 1'b0);
    reg_wr(RegCtrl, 8'h00);
    step(20);

    // Empty frame
    reg_wr(RegStartMid, 8'h01);
    reg_wr(RegEndMid, 8'h01);
    reg_wr(RegEndLo, 8'h00);
    fb = fetch_q.size(); sb = sint_cnt; rb = req_cnt;
    reg_wr(RegCtrl, 8'h01);
    chk("empty_sint_on", 32'(sint), 32'd1);
    step(1);
    chk("empty_sint_off", 32'(sint), 32'd0);
    step(10);
    chk("empty_req", 32'(req_cnt - rb), 32'd0);
    chk("empty_fetch", 32'(fetch_q.size() - fb), 32'd0);
    chk("empty_sint", 32'(sint_cnt - sb), 32'd1);
    reg_rd(RegCtrl, v);         chk("empty_en", 32'(v), 32'd0);

    // Throttle: sreq drops while in REQ
    reg_wr(RegEndLo, 8'h04);
    auto_ack = 1'b0;
    fb = fetch_q.size();
    reg_wr(RegCtrl, 8'h01);
    wait_req("thr");
    sreq = 1'b0;
    step(5);
    chk("thr_req_held", 32'(dma_req), 32'd1);
    auto_ack = 1'b1;
    wait_fetches(fb + 1, "thr");
    step(6);
    chk("thr_fetch", 32'(fetch_q[fb]), 32'h80);
    rd_addr3(RegCurHi, a24);    chk("thr_cur", 32'(a24), 32'h000102);
    chk("thr_idle", 32'(dma_req), 32'd0);
    reg_wr(RegCtrl, 8'h00);
    sreq = 1'b1;
    step(2);

    // Abort during LD1
    fb = fetch_q.size(); sb = sint_cnt; lb = sload_cnt;
    reg_wr(RegCtrl, 8'h01);
    wait_sload("abort");
    reg_wr(RegCtrl, 8'h00);
    step(12);
    chk("abort_sload", 32'(sload_cnt - lb), 32'd2);
    chk("abort_fetch", 32'(fetch_q.size() - fb), 32'd1);
    rd_addr3(RegCurHi, a24);    chk("abort_cur", 32'(a24), 32'h000102);
    chk("abort_sint", 32'(sint_cnt - sb), 32'd0);
    chk("abort_req", 32'(dma_req), 32'd0);

    // Reset in LD2
    reg_wr(RegCtrl, 8'h01);
    wait_sload("rstld2");
    step(1);
    chk("rstld2_in_ld2", 32'(SLOAD_N), 32'd0);
    reset = 1'b1;
    step(1);
    chk("rstld2_sload_n", 32'(SLOAD_N), 32'd1);
    chk("rstld2_req", 32'(dma_req), 32'd0);
    chk("rstld2_sint", 32'(sint), 32'd0);
    chk_all_zero("rstld2_regs");
    reset = 1'b0;
    step(2);

    // Random single frames, loop off
    for (int it = 0; it < 6; it++) begin
      s = 23'($urandom);
      e = s + 23'($urandom_range(0, 4));
      ack_lat = $urandom_range(1, 4);
      set_frame(s, e);
      fb = fetch_q.size(); sb = sint_cnt;
      reg_wr(RegCtrl, 8'h01);
      wait_sints(sb + 1, "rnd");
      step(8);
      model_frame(s, e, 1);
      cmp_fetches("rnd", fb, 1'b1);
      chk("rnd_sint", 32'(sint_cnt - sb), 32'd1);
      reg_rd(RegCtrl, v);       chk("rnd_en", 32'(v), 32'd0);
      rd_addr3(RegCurHi, a24);
      chk("rnd_cur", 32'(a24), 32'({(s < e) ? e : s, 1'b0}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ste_snd_dma_ctrl.md
STE_SND_DMA_CTRL -- requirements
Module: ste_snd_dma_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports, clock and reset first:
- clk32  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- CS  in  1  register select, sound DMA window.
- RW  in  1  1 = read, 0 = write.
- A  in  6 [6:1]  word register index.
- DIN  in  16  CPU write data; only bits 7:0 are used.
- DOUT  out  16  read data, combinational; 0 when not (CS && RW).
- sreq  in  1  shifter FIFO not full.
- dma_ack  in  1  one-cycle bus grant for the sound slot.
- dma_req  out  1  bus request to the MCU arbiter.
- addr  out  23 [23:1]  word address of the current fetch.
- SLOAD_N  out  1  load strobe to the shifter; active low.
- sint  out  1  one-cycle frame-end pulse to the MFP.

Function
REQ-003 Register map, A index, byte value in DOUT[7:0] (DOUT[15:8]=0):
- 0x00: ctrl. bit0 = en, bit1 = loop.
- 0x01/0x02/0x03: start[23:16] / start[15:8] / start[7:1] (bit0 reads 0).
- 0x04/0x05/0x06: current addr, read-only. Writes are ignored.
- 0x07/0x08/0x09: end, same byte layout as start.
- Any other index reads 0. Writes to unmapped indices have no effect.
REQ-004 Writing start or end SHALL update the programmed registers only. The active copies (act_start, act_end) SHALL load from them at each frame start: en rising (0→1 write) or a loop reload.
REQ-005 States: IDLE, REQ, LD1, LD2, ADV.
REQ-006 IDLE→REQ when en && sreq. In REQ, dma_req=1.
REQ-007 REQ→LD1 on dma_ack. addr SHALL be stable from REQ entry until ADV is left. After entering REQ, dma_req SHALL stay high until dma_ack, even if sreq drops or en clears.
REQ-008 SLOAD_N=0 exactly in LD1 and LD2 (2 cycles). SLOAD_N=1 in all other states.
REQ-009 In ADV, addr SHALL increment by 1 (mod 2^23). The next state SHALL be IDLE.
REQ-010 If addr+1 == act_end in ADV:
- sint=1 for that cycle.
- If loop=1: addr←start and the active copies reload.
- If loop=0: en←0 and addr holds at act_end.
REQ-011 On en rising with start >= end (empty frame):
- No fetch SHALL occur.
- sint SHALL pulse once on the next cycle.
- en SHALL clear regardless of loop.
REQ-012 Writing en=0 while the FSM is in LD1, LD2 or ADV SHALL let the strobe and increment complete. The FSM SHALL then stay in IDLE. No sint SHALL be generated.
REQ-013 A CPU write to ctrl in the same cycle as the ADV end-of-frame clear of en: the CPU write SHALL win.
REQ-014 On en rising, addr←start in the cycle of the write. The FSM SHALL NOT leave IDLE in that cycle.
REQ-015 Address arithmetic SHALL be 23-bit unsigned word addresses. Comparisons SHALL be unsigned.

Reset
REQ-016 While reset=1:
- All registers, active copies and addr SHALL be 0.
- State SHALL be IDLE.
- dma_req=0, SLOAD_N=1, sint=0.
REQ-017 Reset asserted mid-transfer SHALL abort it on the next edge: SLOAD_N returns to 1 and dma_req to 0, with no sint.

Structure
REQ-018 A shared package gstmcu_pkg SHALL hold the register index constants (0x00..0x09) and the FSM state enum.
REQ-019 The block SHALL be a single module with no sub-modules. The register file and FSM SHALL live in one file.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic fetch: start=0x000100 (bytes 00,01,00), end=0x000104, en=1, loop=0, sreq=1, dma_ack 2 cycles after each dma_req. Expected: two fetches with addr 0x80 then 0x81; each SLOAD_N low exactly 2 cycles; sint pulse after the 2nd fetch; en reads 0; addr reads 0x000104.
- Loop: same frame with loop=1. Expected: fetch sequence 0x80,0x81,0x80,0x81...; one sint per wrap; en stays 1.
- Mid-frame reprogram: start changed to 0x000200 mid-frame with loop=1. Expected: the current frame finishes at the old end; the next frame begins at addr 0x100.
- Empty frame and throttle: start=end=0x000100, en=1. Expected: no dma_req; one sint; en=0. Then sreq=0 during REQ. Expected: dma_req held until dma_ack, and that fetch completes.
- Abort: en written 0 during LD1. Expected: SLOAD_N still low 2 cycles; addr increments once; then IDLE with dma_req=0 and no sint.
- Reset: reset asserted in LD2. Expected: next cycle SLOAD_N=1, dma_req=0, all registers read 0.
